// File: rtl/accum_input_pkg.sv
// accum_input_pkg: shared types and widths for the accumulator input front end
package accum_input_pkg;
    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_PRESS_WAIT,
        BTN_PRESSED,
        BTN_RELEASE_WAIT
    } btn_state_t;
    localparam int SW_WIDTH_DEFAULT = 10;
    localparam int PRESS_COUNT_W = 8;
endpackage

// File: rtl/accum_input_conditioner_sync_2ff.sv
// sync_2ff: two-flop synchronizer with a configurable reset value
module sync_2ff #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q, sync_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/accum_input_conditioner.sv
// accum_input_conditioner: debounces the run button into one pulse per press and snapshots the switches
module accum_input_conditioner
    import accum_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SW_WIDTH = SW_WIDTH_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     Reset_Clear,
    input  logic                     Run_Accumulate_in,
    input  logic [SW_WIDTH-1:0]      SW,
    output logic                     Run_Pulse,
    output logic [SW_WIDTH-1:0]      Operand,
    output logic                     Held,
    output logic [PRESS_COUNT_W-1:0] Press_Count
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                     btn_sync, btn;
    logic [SW_WIDTH-1:0]      sw_sync;
    btn_state_t               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     run_pulse_q, run_pulse_d;
    logic [SW_WIDTH-1:0]      operand_q, operand_d;
    logic                     held_q, held_d;
    logic [PRESS_COUNT_W-1:0] press_count_q, press_count_d;

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_btn_sync (
        .clk(Clk), .rst_n(Reset_Clear), .d(Run_Accumulate_in), .q(btn_sync)
    );
    sync_2ff #(.WIDTH(SW_WIDTH), .RESET_VAL('0)) u_sw_sync (
        .clk(Clk), .rst_n(Reset_Clear), .d(SW), .q(sw_sync)
    );

    assign btn = ~btn_sync;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        run_pulse_d = 1'b0;
        operand_d = operand_q;
        press_count_d = press_count_q;
        case (state_q)
            BTN_IDLE: if (btn) begin
                state_d = BTN_PRESS_WAIT;
                cnt_d = '0;
            end
            BTN_PRESS_WAIT:
                if (!btn) state_d = BTN_IDLE;
                else if (cnt_q == CNT_LAST) begin
                    state_d = BTN_PRESSED;
                    run_pulse_d = 1'b1;
                    operand_d = sw_sync;
                    press_count_d = press_count_q + PRESS_COUNT_W'(1);
                end else cnt_d = cnt_q + CNT_W'(1);
            BTN_PRESSED: if (!btn) begin
                state_d = BTN_RELEASE_WAIT;
                cnt_d = '0;
            end
            BTN_RELEASE_WAIT:
                if (btn) state_d = BTN_PRESSED;
                else if (cnt_q == CNT_LAST) state_d = BTN_IDLE;
                else cnt_d = cnt_q + CNT_W'(1);
            default: state_d = BTN_RELEASE_WAIT;
        endcase
        held_d = state_d == BTN_PRESSED;
    end

    // Reset lands in RELEASE_WAIT so a button held through reset must be released before it counts
    always_ff @(posedge Clk) begin
        if (!Reset_Clear) begin
            state_q <= BTN_RELEASE_WAIT;
            cnt_q <= '0;
            run_pulse_q <= 1'b0;
            operand_q <= '0;
            held_q <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            run_pulse_q <= run_pulse_d;
            operand_q <= operand_d;
            held_q <= held_d;
            press_count_q <= press_count_d;
        end
    end

    assign Run_Pulse = run_pulse_q;
    assign Operand = operand_q;
    assign Held = held_q;
    assign Press_Count = press_count_q;
endmodule

// File: tb/tb_accum_input_conditioner.sv
// tb_accum_input_conditioner: randomized and directed checks against a run-length debounce model
module tb_accum_input_conditioner;
    localparam int D = 4;
    localparam int W = 10;

    logic         Clk = 1'b0;
    logic         Reset_Clear = 1'b0;
    logic         Run_Accumulate_in = 1'b1;
    logic [W-1:0] SW = '0;
    logic         Run_Pulse, Held;
    logic [W-1:0] Operand;
    logic [7:0]   Press_Count;

    accum_input_conditioner #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(W)) dut (
        .Clk(Clk), .Reset_Clear(Reset_Clear), .Run_Accumulate_in(Run_Accumulate_in), .SW(SW),
        .Run_Pulse(Run_Pulse), .Operand(Operand), .Held(Held), .Press_Count(Press_Count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int           cyc;
        logic [W-1:0] op;
        logic [7:0]   cnt;
    } exp_t;

    exp_t         exp_q[$];
    int           compared = 0, mismatched = 0, cyc = 0, pulses_seen = 0;
    logic         exp_held = 1'b0;
    logic [W-1:0] exp_op = '0;
    logic [7:0]   exp_cnt = '0;
    logic [1:0]   btn_dly = 2'b11;
    logic [W-1:0] sw_dly0 = '0, sw_dly1 = '0;
    int           low_run = 1, high_run = 0;
    bit           armed = 1'b0;
    bit           s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Model: inputs reach the debouncer two edges late. A press is accepted when D+1 consecutive
    // pressed samples follow a completed run of D+1 released samples; reset counts as one released sample.
    initial forever begin
        @(posedge Clk);
        cyc++;
        if (!Reset_Clear) begin
            btn_dly = 2'b11; sw_dly0 = '0; sw_dly1 = '0;
            low_run = 1; high_run = 0; armed = 1'b0;
            exp_held = 1'b0; exp_op = '0; exp_cnt = '0;
        end else begin
            s = ~btn_dly[1];
            if (s) begin high_run++; low_run = 0; end
            else begin low_run++; high_run = 0; end
            if (!armed && low_run >= D + 1) armed = 1'b1;
            if (armed && s && high_run == D + 1) begin
                armed = 1'b0;
                exp_cnt++;
                exp_op = sw_dly1;
                exp_q.push_back('{cyc: cyc, op: exp_op, cnt: exp_cnt});
            end
            exp_held = !armed && s;
            btn_dly = {btn_dly[0], Run_Accumulate_in};
            sw_dly1 = sw_dly0;
            sw_dly0 = SW;
        end
    end

    initial begin
        exp_t e;
        @(posedge Clk);
        forever begin
            @(negedge Clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("missing_pulse", 32'(Run_Pulse), 32'(1));
            end
            if (Run_Pulse) begin
                if (exp_q.size() == 0) chk("unexpected_pulse", 32'(Run_Pulse), 32'(0));
                else begin
                    e = exp_q.pop_front();
                    pulses_seen++;
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    chk("pulse_operand", 32'(Operand), 32'(e.op));
                    chk("pulse_count", 32'(Press_Count), 32'(e.cnt));
                end
            end
            chk("held", 32'(Held), 32'(exp_held));
            chk("operand", 32'(Operand), 32'(exp_op));
            chk("press_count", 32'(Press_Count), 32'(exp_cnt));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        Reset_Clear = 1'b0;
        cycles(n);
        Reset_Clear = 1'b1;
    endtask

    initial begin
        int p0;
        cycles(3);
        chk("reset_pulse", 32'(Run_Pulse), 32'(0));
        chk("reset_operand", 32'(Operand), 32'(0));
        chk("reset_held", 32'(Held), 32'(0));
        chk("reset_count", 32'(Press_Count), 32'(0));
        Reset_Clear = 1'b1;
        cycles(10);
        chk("idle_no_pulse", 32'(pulses_seen), 32'(0));

        SW = 10'h007;
        cycles(3);
        Run_Accumulate_in = 1'b0;
        cycles(20);
        chk("clean_operand", 32'(Operand), 32'h007);
        chk("clean_count", 32'(Press_Count), 32'(1));
        chk("clean_held", 32'(Held), 32'(1));
        chk("clean_pulses", 32'(pulses_seen), 32'(1));
        Run_Accumulate_in = 1'b1;
        repeat (12) begin SW = W'($urandom); cycles(1); end
        chk("release_held", 32'(Held), 32'(0));
        chk("operand_stable", 32'(Operand), 32'h007);
        SW = 10'h00B;
        cycles(3);
        Run_Accumulate_in = 1'b0;
        cycles(20);
        chk("second_operand", 32'(Operand), 32'h00B);
        chk("second_count", 32'(Press_Count), 32'(2));
        Run_Accumulate_in = 1'b1;
        cycles(12);

        do_reset(3);
        cycles(10);
        p0 = pulses_seen;
        Run_Accumulate_in = 1'b0; cycles(2);
        Run_Accumulate_in = 1'b1; cycles(1);
        Run_Accumulate_in = 1'b0; cycles(2);
        Run_Accumulate_in = 1'b1; cycles(1);
        Run_Accumulate_in = 1'b0; cycles(20);
        chk("bounce_pulses", 32'(pulses_seen - p0), 32'(1));
        chk("bounce_count", 32'(Press_Count), 32'(1));

        do_reset(2);
        cycles(20);
        chk("held_reset_count", 32'(Press_Count), 32'(0));
        chk("held_reset_held", 32'(Held), 32'(1));
        chk("held_reset_pulses", 32'(pulses_seen - p0), 32'(1));
        Run_Accumulate_in = 1'b1; cycles(8);
        Run_Accumulate_in = 1'b0; cycles(20);
        chk("held_reset_repress", 32'(Press_Count), 32'(1));
        Run_Accumulate_in = 1'b1; cycles(12);

        repeat (200) begin
            Run_Accumulate_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) SW = W'($urandom);
            if ($urandom_range(0, 29) == 0) do_reset(1);
            cycles($urandom_range(1, 2 * D + 3));
        end
        Run_Accumulate_in = 1'b1;
        cycles(12);

        do_reset(2);
        cycles(10);
        p0 = pulses_seen;
        for (int i = 0; i < 256; i++) begin
            SW = W'($urandom);
            Run_Accumulate_in = 1'b0; cycles(9);
            Run_Accumulate_in = 1'b1; cycles(9);
        end
        chk("wrap_count", 32'(Press_Count), 32'(0));
        chk("wrap_pulses", 32'(pulses_seen - p0), 32'(256));

        cycles(10);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
